fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID boundary of the five-stage MIPS pipeline. It owns the PC register, drives the synchronous instruction memory, and presents the fetched instruction and its PC+4 to the ID stage, where the control unit decodes it. It consumes the control unit's `npc_mux_sel` and `lw_stall` outputs. Branch and jump decisions are taken in ID with one architectural delay slot, so the stage never flushes.

## Interface
- `RESET_PC`, 32'h0040_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  `lw_stall` from the control unit; freezes PC and the IF/ID contents.
- `npc_mux_sel`  in  3  next-PC select from the control unit, for the instruction currently in ID.
- `branch_target`  in  32  ID-computed `id_pc4 + (sext(imm16) << 2)`.
- `jump_target`  in  32  ID-computed `{id_pc4[31:28], instr_index, 2'b00}`.
- `jr_target`  in  32  bypassed rs value from ID.
- `imem_addr`  out  32  instruction memory address; equals `pc`.
- `imem_en`  out  1  instruction memory read enable.
- `imem_rdata`  in  32  synchronous read data; word at the `imem_addr` of the previous cycle.
- `if_pc`  out  32  current PC register, used for debug and trace.
- `id_instr`  out  32  instruction in ID; feeds the control unit's op/func and the register-file address fields.
- `id_pc4`  out  32  PC+4 of the instruction in ID.
- `id_valid`  out  1  ID holds a real fetched instruction.

## Operation
- State:
  - `pc` (32)
  - `id_pc4_r` (32)
  - `id_valid_r` (1)
  - `hold_instr` (32)
  - `hold_valid` (1)
- Next PC, used only when `stall == 0`:
  - If `id_valid == 0`: `pc + 4`, and `npc_mux_sel` is ignored.
  - Otherwise, by `npc_mux_sel`:
    - 3'b000: `pc + 4`
    - 3'b001: `branch_target`
    - 3'b010: `jump_target`
    - 3'b011: `jr_target`
    - 3'b1xx: `pc + 4`
  - Bits [1:0] of the selected value are forced to 00. There is no alignment exception.
  - Adds are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Non-stall edge:
  - `pc <= npc`
  - `id_pc4_r <= pc + 4`
  - `id_valid_r <= 1`
  - `hold_valid <= 0`
- Stall edge:
  - `pc` and `id_pc4_r` hold.
  - If `hold_valid == 0`: `hold_instr <= imem_rdata` and `hold_valid <= 1`. This captures the ID instruction before memory data is overwritten.
  - If `hold_valid == 1`: `hold_instr` holds.
- `imem_en` = `rst_n`. Memory re-reads `pc` every cycle, including stall cycles, so the word at `pc` is on `imem_rdata` on the cycle stall releases.
- `id_instr`:
  - `id_valid_r == 0`: 32'h0000_0000 (nop).
  - `id_valid_r == 1` and `hold_valid == 1`: `hold_instr`.
  - Otherwise: `imem_rdata`.
- Delay slot: when a taken branch is in ID, its delay slot (`pc`) is already being fetched. The delay slot enters ID next cycle, and the target is fetched next cycle.
- Bubble insertion into EXE on stall is the ID/EXE register's job. `id_valid` stays 1 while stalled.

## Timing
- Async reset: `pc = RESET_PC`, `id_pc4_r = 0`, `id_valid_r = 0`, `hold_instr = 0`, `hold_valid = 0`.
  - Outputs during reset: `imem_addr = RESET_PC`, `imem_en = 0`, `id_instr = 0`, `id_pc4 = 0`, `id_valid = 0`.
- First edge after deassert:
  - `pc = RESET_PC + 4`
  - `id_valid = 1`
  - `id_instr = mem[RESET_PC]`
  - `id_pc4 = RESET_PC + 4`
- Fetch-to-ID latency: 1 cycle. Taken-branch redirect: the target reaches ID 2 cycles after the branch is in ID, with the delay slot in between.
- Multi-cycle stall: `id_instr` and `id_pc4` remain constant for every stall cycle. Release resumes with the next-PC mux evaluated on the release cycle, using operands that are bypassed by then.
- Reset asserted mid-stall or mid-branch: all state clears immediately, with no pending redirect retained.
- `npc_mux_sel` and the target inputs are sampled only on non-stall edges with `id_valid == 1`.

## Test plan
- **Reset and sequential fetch.** Memory holds incrementing words at 0x0040_0000... -> over 4 cycles, `id_instr`/`id_pc4` sequence is:
  - mem[0x400000] / 0x400004
  - mem[0x400004] / 0x400008
  - `if_pc` = 0x400004, 0x400008, ...
- **Taken beq with delay slot.** Branch at 0x400008, `npc_mux_sel = 001`, `branch_target = 0x400020` -> `id_instr` sequence is I(0x400008), I(0x40000C), I(0x400020).
- **j and jr.** `jump_target = 0x00400100` -> delay slot, then I(0x400100). `jr_target = 0x00400103` -> `pc` = 0x00400100, low bits forced to 00.
- **lw-use stall.** `stall` high for 1 cycle, then for 3 cycles, with `imem_rdata` changing underneath -> `id_instr`/`id_pc4` frozen on the held values, `pc` constant. After release, the next instruction is PC+4 with no skip and no duplicate.
- **Stall with a branch in ID.** `npc_mux_sel = 001` with `branch_target = 0xDEAD0000` while stalled, then `branch_target = 0x400040` on the release cycle -> redirect to 0x400040 only.
- **Reset mid-stall.** Assert `rst_n = 0` during a stall -> immediately:
  - `id_valid = 0`, `id_instr = 0`, `hold_valid = 0`, `pc = RESET_PC`
  - After deassert, fetch restarts from `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline boundary: owns the PC, drives the
// synchronous instruction memory and holds the ID-stage instruction across stalls.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [2:0]  npc_mux_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid
);

   logic [31:0] pc;
   logic [31:0] id_pc4_r;
   logic        id_valid_r;
   logic [31:0] hold_instr;
   logic        hold_valid;

   logic [31:0] pc_plus4;
   logic [31:0] npc_raw;
   logic [31:0] npc;

   assign pc_plus4 = pc + 32'd4;

   // The select only has meaning once a real instruction sits in ID.
   always_comb begin
      // NOTE: default first so every path assigns npc_raw and no latch is inferred.
      npc_raw = pc_plus4;
      if (id_valid_r) begin
         case (npc_mux_sel)
            3'b001:  npc_raw = branch_target;
            3'b010:  npc_raw = jump_target;
            3'b011:  npc_raw = jr_target;
            default: npc_raw = pc_plus4;
         endcase
      end
   end

   assign npc = {npc_raw[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pc         <= RESET_PC;
         id_pc4_r   <= 32'd0;
         id_valid_r <= 1'b0;
         hold_instr <= 32'd0;
         hold_valid <= 1'b0;
      end else if (!stall) begin
         pc         <= npc;
         id_pc4_r   <= pc_plus4;
         id_valid_r <= 1'b1;
         hold_valid <= 1'b0;
      end else if (!hold_valid) begin
         // Memory keeps re-reading pc, so the ID word must be captured now.
         hold_instr <= imem_rdata;
         hold_valid <= 1'b1;
      end
   end

   assign imem_addr = pc;
   assign imem_en   = rst_n;
   assign if_pc     = pc;
   assign id_pc4    = id_pc4_r;
   assign id_valid  = id_valid_r;

   always_comb begin
      id_instr = 32'd0;
      if (id_valid_r)
         id_instr = hold_valid ? hold_instr : imem_rdata;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: an architectural PC/ID model compared every
// cycle, plus directed scenarios with hand-computed addresses.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic [2:0]  npc_mux_sel = 3'b000;
   logic [31:0] branch_target = 32'd0;
   logic [31:0] jump_target = 32'd0;
   logic [31:0] jr_target = 32'd0;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] if_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;

   int n_vec = 0;
   int n_err = 0;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .npc_mux_sel(npc_mux_sel),
      .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
      .if_pc(if_pc), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid)
   );

   always #5 clk = ~clk;

   // Distinct word per address; stands in for the program image.
   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return 32'hA000_0000 ^ {2'b00, a[31:2]};
   endfunction

   // Synchronous instruction memory.
   always @(posedge clk)
      if (imem_en) imem_rdata <= instr_at(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: what ID holds and where the PC points.
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_instr = 32'd0;
   logic [31:0] m_pc4 = 32'd0;
   logic        m_valid = 1'b0;

   function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic valid);
      logic [31:0] t;
      t = cur_pc + 32'd4;
      if (valid) begin
         if (npc_mux_sel == 3'd1)      t = branch_target;
         else if (npc_mux_sel == 3'd2) t = jump_target;
         else if (npc_mux_sel == 3'd3) t = jr_target;
      end
      return t & 32'hFFFF_FFFC;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    <= RESET_PC;
         m_instr <= 32'd0;
         m_pc4   <= 32'd0;
         m_valid <= 1'b0;
      end else if (!stall) begin
         m_instr <= instr_at(m_pc);
         m_pc4   <= m_pc + 32'd4;
         m_valid <= 1'b1;
         m_pc    <= model_npc(m_pc, m_valid);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_if_pc", if_pc, m_pc);
         check("cyc_imem_addr", imem_addr, m_pc);
         check("cyc_imem_en", {31'd0, imem_en}, 32'd1);
         check("cyc_id_valid", {31'd0, id_valid}, {31'd0, m_valid});
         check("cyc_id_instr", id_instr, m_valid ? m_instr : 32'd0);
         check("cyc_id_pc4", id_pc4, m_pc4);
      end else begin
         check("rst_imem_addr", imem_addr, RESET_PC);
         check("rst_imem_en", {31'd0, imem_en}, 32'd0);
         check("rst_id_valid", {31'd0, id_valid}, 32'd0);
         check("rst_id_instr", id_instr, 32'd0);
         check("rst_id_pc4", id_pc4, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_id(input string name, input logic [31:0] pc_exp,
                            input logic [31:0] instr_addr, input logic [31:0] pc4_exp);
      check({name, "_pc"}, if_pc, pc_exp);
      check({name, "_instr"}, id_instr, instr_at(instr_addr));
      check({name, "_pc4"}, id_pc4, pc4_exp);
      check({name, "_valid"}, {31'd0, id_valid}, 32'd1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(); tick();
      check("reset_addr", imem_addr, 32'h0040_0000);
      check("reset_instr", id_instr, 32'd0);
      check("reset_valid", {31'd0, id_valid}, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch.
      tick(); expect_id("seq1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004);
      tick(); expect_id("seq2", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008);
      tick(); expect_id("seq3", 32'h0040_000C, 32'h0040_0008, 32'h0040_000C);

      // Taken branch in ID at 0x400008: delay slot, then target.
      npc_mux_sel = 3'b001; branch_target = 32'h0040_0020;
      tick(); expect_id("beq_ds", 32'h0040_0020, 32'h0040_000C, 32'h0040_0010);
      npc_mux_sel = 3'b000;
      tick(); expect_id("beq_tgt", 32'h0040_0024, 32'h0040_0020, 32'h0040_0024);

      // Jump.
      npc_mux_sel = 3'b010; jump_target = 32'h0040_0100;
      tick(); expect_id("j_ds", 32'h0040_0100, 32'h0040_0024, 32'h0040_0028);
      npc_mux_sel = 3'b000;
      tick(); expect_id("j_tgt", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104);

      // Register jump with misaligned target: low bits forced to 00.
      npc_mux_sel = 3'b011; jr_target = 32'h0040_0103;
      tick(); expect_id("jr_ds", 32'h0040_0100, 32'h0040_0104, 32'h0040_0108);
      npc_mux_sel = 3'b000;
      tick(); expect_id("jr_tgt", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104);

      // Reserved select values fall through to sequential.
      npc_mux_sel = 3'b101; branch_target = 32'h1111_1110; jump_target = 32'h2222_2220;
      jr_target = 32'h3333_3330;
      tick(); expect_id("sel1xx", 32'h0040_0108, 32'h0040_0104, 32'h0040_0108);
      npc_mux_sel = 3'b000;

      // One-cycle stall.
      stall = 1'b1;
      tick(); expect_id("st1_frz", 32'h0040_0108, 32'h0040_0104, 32'h0040_0108);
      stall = 1'b0;
      tick(); expect_id("st1_rel", 32'h0040_010C, 32'h0040_0108, 32'h0040_010C);

      // Three-cycle stall.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); expect_id("st3_frz", 32'h0040_010C, 32'h0040_0108, 32'h0040_010C);
      end
      stall = 1'b0;
      tick(); expect_id("st3_rel", 32'h0040_0110, 32'h0040_010C, 32'h0040_0110);

      // Branch in ID while stalled: only the release-cycle target counts.
      stall = 1'b1; npc_mux_sel = 3'b001; branch_target = 32'hDEAD_0000;
      tick(); expect_id("stbr_frz1", 32'h0040_0110, 32'h0040_010C, 32'h0040_0110);
      tick(); expect_id("stbr_frz2", 32'h0040_0110, 32'h0040_010C, 32'h0040_0110);
      stall = 1'b0; branch_target = 32'h0040_0040;
      tick(); expect_id("stbr_ds", 32'h0040_0040, 32'h0040_0110, 32'h0040_0114);
      npc_mux_sel = 3'b000;
      tick(); expect_id("stbr_tgt", 32'h0040_0044, 32'h0040_0040, 32'h0040_0044);

      // Wrap from the top of the address space.
      npc_mux_sel = 3'b011; jr_target = 32'hFFFF_FFFE;
      tick(); expect_id("wrap_ds", 32'hFFFF_FFFC, 32'h0040_0044, 32'h0040_0048);
      npc_mux_sel = 3'b000;
      tick(); expect_id("wrap_top", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000);
      tick(); expect_id("wrap_zero", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004);

      // Reset asserted in the middle of a stall with a redirect requested.
      stall = 1'b1; npc_mux_sel = 3'b010; jump_target = 32'h0050_0000;
      tick(); expect_id("rst_st_frz", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, id_valid}, 32'd0);
      check("midrst_instr", id_instr, 32'd0);
      check("midrst_pc", if_pc, RESET_PC);
      check("midrst_hold", {31'd0, dut.hold_valid}, 32'd0);
      stall = 1'b0; npc_mux_sel = 3'b000;
      tick(); tick();
      rst_n = 1'b1;
      tick(); expect_id("restart1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004);
      tick(); expect_id("restart2", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timed out");
   end

endmodule
